// File: rtl/sim_status_pkg.sv
// Shared types for the simulation-status / store-trace unit.
package sim_status_pkg;

  typedef enum logic [1:0] {
    ST_RUN     = 2'd0,
    ST_PASS    = 2'd1,
    ST_FAIL    = 2'd2,
    ST_TIMEOUT = 2'd3
  } sim_state_t;

  localparam logic [63:0] TOHOST_PASS = 64'd1;

  typedef struct packed {
    logic [60:0] addr;
    logic [63:0] data;
  } log_entry_t;

endpackage

// File: rtl/store_log_fifo.sv
// Show-ahead synchronous FIFO of store-log entries; a push is accepted at full when a pop frees a slot.
module store_log_fifo
  import sim_status_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       push_i,
  input  log_entry_t push_entry_i,
  input  logic       pop_i,
  output log_entry_t head_o,
  output logic       valid_o,
  output logic       full_o
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  log_entry_t     mem_q [DEPTH];
  logic [AW-1:0]  wr_ptr_q, rd_ptr_q;
  logic [AW:0]    cnt_q;
  logic           pop_ok, push_ok;

  assign valid_o = (cnt_q != '0);
  assign full_o  = (cnt_q == FULL_CNT);
  assign pop_ok  = pop_i && valid_o;
  assign push_ok = push_i && (!full_o || pop_ok);
  // Head is masked so the data outputs read zero while empty.
  assign head_o  = valid_o ? mem_q[rd_ptr_q] : '0;

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      if (push_ok) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop_ok)  rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({push_ok, pop_ok})
        2'b10:   cnt_q <= cnt_q + 1'b1;
        2'b01:   cnt_q <= cnt_q - 1'b1;
        default: cnt_q <= cnt_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= push_entry_i;
  end

endmodule

// File: rtl/sim_status_unit.sv
// Snoops M-stage stores: tohost pass/fail decode, cycle watchdog and a store-trace FIFO.
module sim_status_unit
  import sim_status_pkg::*;
#(
  parameter logic [63:0] TOHOST_ADDR    = 64'h0000_0000_0000_1000,
  parameter int          TIMEOUT_CYCLES = 10000,
  parameter int          LOG_DEPTH      = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_write_i,
  input  logic [63:0] mem_addr_i,
  input  logic [63:0] mem_wdata_i,
  input  logic        log_pop_i,
  output logic        log_valid_o,
  output logic [60:0] log_addr_o,
  output logic [63:0] log_data_o,
  output logic        log_overflow_o,
  output logic [31:0] store_count_o,
  output logic [31:0] cycle_count_o,
  output logic        done_o,
  output logic        pass_o,
  output logic        timeout_o,
  output logic [62:0] fail_code_o
);

  localparam logic [31:0] TO_LAST = 32'(TIMEOUT_CYCLES - 1);

  sim_state_t  st_q, st_d;
  logic [31:0] cycle_q, store_cnt_q;
  logic        ovf_q;
  logic [62:0] fail_code_q, fail_code_d;
  logic        run, addr_hit, tohost_hit, ord_store, fifo_full, drop;
  log_entry_t  push_entry, head;
  logic        unused_addr_lsb;

  // Byte offset within the doubleword is irrelevant to both decode and log.
  assign unused_addr_lsb = ^mem_addr_i[2:0];

  assign run        = (st_q == ST_RUN);
  assign addr_hit   = (mem_addr_i[63:3] == TOHOST_ADDR[63:3]);
  assign tohost_hit = run && mem_write_i && addr_hit;
  assign ord_store  = run && mem_write_i && !addr_hit;
  assign drop       = ord_store && fifo_full && !(log_pop_i && log_valid_o);
  assign push_entry = '{addr: mem_addr_i[63:3], data: mem_wdata_i};

  always_comb begin
    st_d        = st_q;
    fail_code_d = fail_code_q;
    if (tohost_hit) begin
      if (mem_wdata_i == TOHOST_PASS) begin
        st_d = ST_PASS;
      end else if (mem_wdata_i != 64'd0) begin
        st_d        = ST_FAIL;
        fail_code_d = mem_wdata_i[63:1];
      end
    end
    // A real tohost verdict in the final cycle beats the watchdog.
    if (run && (cycle_q == TO_LAST) && (st_d == ST_RUN)) st_d = ST_TIMEOUT;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      st_q        <= ST_RUN;
      cycle_q     <= '0;
      store_cnt_q <= '0;
      ovf_q       <= 1'b0;
      fail_code_q <= '0;
    end else begin
      st_q        <= st_d;
      fail_code_q <= fail_code_d;
      if (run)       cycle_q     <= cycle_q + 1'b1;
      if (ord_store) store_cnt_q <= store_cnt_q + 1'b1;
      if (drop)      ovf_q       <= 1'b1;
    end
  end

  store_log_fifo #(.DEPTH(LOG_DEPTH)) u_log (
    .clk         (clk),
    .rst         (rst),
    .push_i      (ord_store),
    .push_entry_i(push_entry),
    .pop_i       (log_pop_i),
    .head_o      (head),
    .valid_o     (log_valid_o),
    .full_o      (fifo_full)
  );

  assign log_addr_o     = head.addr;
  assign log_data_o     = head.data;
  assign log_overflow_o = ovf_q;
  assign store_count_o  = store_cnt_q;
  assign cycle_count_o  = cycle_q;
  assign done_o         = !run;
  assign pass_o         = (st_q == ST_PASS);
  assign timeout_o      = (st_q == ST_TIMEOUT);
  assign fail_code_o    = fail_code_q;

endmodule

// File: tb/tb_sim_status_unit.sv
// Directed bench for sim_status_unit with a 20-cycle watchdog and a 4-deep log.
module tb_sim_status_unit;

  localparam logic [63:0] TOHOST = 64'h1000;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        mem_write = 1'b0;
  logic [63:0] mem_addr = '0;
  logic [63:0] mem_wdata = '0;
  logic        log_pop = 1'b0;
  logic        log_valid, log_overflow, done, pass, timeout;
  logic [60:0] log_addr;
  logic [63:0] log_data;
  logic [31:0] store_count, cycle_count;
  logic [62:0] fail_code;

  int n_chk = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  sim_status_unit #(
    .TOHOST_ADDR   (TOHOST),
    .TIMEOUT_CYCLES(20),
    .LOG_DEPTH     (4)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .mem_write_i   (mem_write),
    .mem_addr_i    (mem_addr),
    .mem_wdata_i   (mem_wdata),
    .log_pop_i     (log_pop),
    .log_valid_o   (log_valid),
    .log_addr_o    (log_addr),
    .log_data_o    (log_data),
    .log_overflow_o(log_overflow),
    .store_count_o (store_count),
    .cycle_count_o (cycle_count),
    .done_o        (done),
    .pass_o        (pass),
    .timeout_o     (timeout),
    .fail_code_o   (fail_code)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  task automatic store(input logic [63:0] a, input logic [63:0] d);
    mem_write = 1'b1; mem_addr = a; mem_wdata = d;
    tick();
    mem_write = 1'b0;
  endtask

  task automatic pop();
    log_pop = 1'b1;
    tick();
    log_pop = 1'b0;
  endtask

  task automatic chk_head(input string tag, input logic [60:0] a, input logic [63:0] d);
    chk({tag, "_vld"}, 64'(log_valid), 64'd1);
    chk({tag, "_addr"}, 64'(log_addr), 64'(a));
    chk({tag, "_data"}, log_data, d);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_vld"}, 64'(log_valid), 64'd0);
    chk({tag, "_laddr"}, 64'(log_addr), 64'd0);
    chk({tag, "_ldata"}, log_data, 64'd0);
    chk({tag, "_ovf"}, 64'(log_overflow), 64'd0);
    chk({tag, "_scnt"}, 64'(store_count), 64'd0);
    chk({tag, "_ccnt"}, 64'(cycle_count), 64'd0);
    chk({tag, "_done"}, 64'(done), 64'd0);
    chk({tag, "_pass"}, 64'(pass), 64'd0);
    chk({tag, "_tmo"}, 64'(timeout), 64'd0);
    chk({tag, "_fcode"}, 64'(fail_code), 64'd0);
  endtask

  initial begin
    // Reset state
    tick(); tick();
    do_reset();
    chk_all_zero("rst");

    // Two logged stores then tohost <- 1
    store(64'h40, 64'd5);
    chk_head("t1_first", 61'd8, 64'd5);
    store(64'h48, 64'd7);
    store(TOHOST, 64'd1);
    chk("t1_done", 64'(done), 64'd1);
    chk("t1_pass", 64'(pass), 64'd1);
    chk("t1_scnt", 64'(store_count), 64'd2);
    store(64'h50, 64'd9);
    chk("t1_scnt_after", 64'(store_count), 64'd2);
    chk("t1_ccnt", 64'(cycle_count), 64'd3);
    chk_head("t1_h0", 61'd8, 64'd5);
    pop();
    chk_head("t1_h1", 61'd9, 64'd7);
    pop();
    chk("t1_empty", 64'(log_valid), 64'd0);
    pop();
    chk("t1_empty_pop", 64'(log_valid), 64'd0);

    // tohost <- 0 ignored, then tohost <- 7 fails (sub-doubleword offset still hits)
    do_reset();
    store(TOHOST, 64'd0);
    chk("t2_zero_done", 64'(done), 64'd0);
    chk("t2_zero_scnt", 64'(store_count), 64'd0);
    chk("t2_zero_vld", 64'(log_valid), 64'd0);
    store(TOHOST + 64'd4, 64'd7);
    chk("t2_done", 64'(done), 64'd1);
    chk("t2_fcode", 64'(fail_code), 64'd3);
    chk("t2_pass", 64'(pass), 64'd0);
    chk("t2_tmo", 64'(timeout), 64'd0);

    // Watchdog
    do_reset();
    repeat (19) tick();
    chk("t3_tmo_e19", 64'(timeout), 64'd0);
    chk("t3_ccnt_e19", 64'(cycle_count), 64'd19);
    tick();
    chk("t3_tmo_e20", 64'(timeout), 64'd1);
    chk("t3_done", 64'(done), 64'd1);
    chk("t3_ccnt_e20", 64'(cycle_count), 64'd20);
    repeat (3) tick();
    chk("t3_ccnt_frozen", 64'(cycle_count), 64'd20);
    chk("t3_fcode", 64'(fail_code), 64'd0);

    // tohost pass coincides with timeout
    do_reset();
    repeat (19) tick();
    store(TOHOST, 64'd1);
    chk("t4_pass", 64'(pass), 64'd1);
    chk("t4_tmo", 64'(timeout), 64'd0);
    chk("t4_ccnt", 64'(cycle_count), 64'd20);

    // Overflow with 4-deep log, then push+pop at full
    do_reset();
    for (int i = 0; i < 9; i++) store(64'h100 + 64'(8 * i), 64'hA0 + 64'(i));
    chk("t5_ovf", 64'(log_overflow), 64'd1);
    chk("t5_scnt", 64'(store_count), 64'd9);
    chk_head("t5_h0", 61'h20, 64'hA0);
    mem_write = 1'b1; mem_addr = 64'h200; mem_wdata = 64'hBB; log_pop = 1'b1;
    tick();
    mem_write = 1'b0; log_pop = 1'b0;
    chk("t5_scnt_pp", 64'(store_count), 64'd10);
    chk_head("t5_h1", 61'h21, 64'hA1);
    pop();
    chk_head("t5_h2", 61'h22, 64'hA2);
    pop();
    chk_head("t5_h3", 61'h23, 64'hA3);
    pop();
    chk_head("t5_tail", 61'h40, 64'hBB);
    pop();
    chk("t5_empty", 64'(log_valid), 64'd0);
    chk("t5_ovf_sticky", 64'(log_overflow), 64'd1);

    // Reset mid-test after logged stores and FAIL
    do_reset();
    store(64'h40, 64'd1);
    store(64'h48, 64'd2);
    store(TOHOST, 64'd5);
    chk("t6_fail_done", 64'(done), 64'd1);
    chk("t6_fail_code", 64'(fail_code), 64'd2);
    do_reset();
    chk_all_zero("t6_rst");
    store(TOHOST, 64'd1);
    chk("t6_pass", 64'(pass), 64'd1);
    chk("t6_done", 64'(done), 64'd1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
